// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, clear, load and registered terminal-count pulse.
// Define MOD_COUNTER_SAT_EN to hold at the terminal value instead of wrapping.
module mod_counter #(
    parameter int unsigned     WIDTH       = 4,
    parameter longint unsigned MODULUS     = 16,
    parameter int unsigned     PRESCALE    = 1,
    parameter int unsigned     RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc
);

    localparam int unsigned       PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  RST_VAL  = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tc_q, tc_d;
    logic              at_term;
    logic [WIDTH-1:0]  step_val;

    always_comb begin
        at_term  = up ? (cnt_q == MAX_VAL) : (cnt_q == '0);
        step_val = cnt_q;
        if (at_term) begin
`ifdef MOD_COUNTER_SAT_EN
            step_val = cnt_q;
`else
            step_val = up ? '0 : MAX_VAL;
`endif
        end else begin
            step_val = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        pcnt_d = pcnt_q;
        tc_d   = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            pcnt_d = '0;
        end else if (load) begin
            // Out-of-range loads are clamped so the count never leaves 0..MODULUS-1.
            cnt_d  = (load_value > MAX_VAL) ? MAX_VAL : load_value;
            pcnt_d = '0;
        end else if (enable) begin
            if (pcnt_q == PCNT_MAX) begin
                pcnt_d = '0;
                cnt_d  = step_val;
                tc_d   = at_term;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= RST_VAL;
            pcnt_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            tc_q   <= tc_d;
        end
    end

    assign counter_out = cnt_q;
    assign tc          = tc_q;

endmodule
